// File: rtl/wasde_key_debounce.sv
// WASDE navigation button front end: per-key 2-flop synchroniser, debounce
// counter and hold/auto-repeat FSM producing level, press, release and repeat.
module wasde_key_debounce #(
   parameter int N_KEYS          = 5,
   parameter int DEBOUNCE_CYCLES = 2_000_000,
   parameter int HOLD_CYCLES     = 50_000_000,
   parameter int REPEAT_CYCLES   = 15_000_000,
   parameter int CNT_W           = 26
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_raw,
   input  logic [N_KEYS-1:0] repeat_en,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat
);

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_t;

   genvar gi;
   generate
      for (gi = 0; gi < N_KEYS; gi++) begin : g_key
         logic             s1_reg;
         logic             s2_reg;
         logic             level_reg;
         logic             level_next;
         logic             press_reg;
         logic             press_next;
         logic             release_reg;
         logic             release_next;
         logic [CNT_W-1:0] db_cnt_reg;
         logic [CNT_W-1:0] db_cnt_next;
         logic             mismatch;
         logic             db_done;
         logic             rise_evt;
         logic             fall_evt;
         rep_state_t       state_reg;
         rep_state_t       state_next;
         logic [CNT_W-1:0] rp_cnt_reg;
         logic [CNT_W-1:0] rp_cnt_next;
         logic             repeat_reg;
         logic             repeat_next;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s1_reg <= 1'b0;
               s2_reg <= 1'b0;
            end else begin
               s1_reg <= key_raw[gi];
               s2_reg <= s1_reg;
            end
         end

         // Any cycle where the synchronised input agrees with the level restarts the count.
         assign mismatch = s2_reg ^ level_reg;
         assign db_done  = mismatch && (db_cnt_reg == DB_LAST);
         assign rise_evt = db_done && s2_reg;
         assign fall_evt = db_done && !s2_reg;

         always_comb begin
            db_cnt_next  = '0;
            level_next   = level_reg;
            press_next   = rise_evt;
            release_next = fall_evt;
            if (mismatch && !db_done) begin
               db_cnt_next = db_cnt_reg + 1'b1;
            end
            if (db_done) begin
               level_next = s2_reg;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               db_cnt_reg  <= '0;
               level_reg   <= 1'b0;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
            end else begin
               db_cnt_reg  <= db_cnt_next;
               level_reg   <= level_next;
               press_reg   <= press_next;
               release_reg <= release_next;
            end
         end

         // The FSM acts on the same-cycle debounce events so its pulses line up
         // exactly with the registered press/release outputs.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_reg  <= ST_IDLE;
               rp_cnt_reg <= '0;
               repeat_reg <= 1'b0;
            end else begin
               state_reg  <= state_next;
               rp_cnt_reg <= rp_cnt_next;
               repeat_reg <= repeat_next;
            end
         end

         always_comb begin
            state_next  = state_reg;
            rp_cnt_next = rp_cnt_reg;
            case (state_reg)
               ST_IDLE: begin
                  rp_cnt_next = '0;
                  if (rise_evt) begin
                     state_next = ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  if (rp_cnt_reg == HOLD_LAST) begin
                     // Saturate here until repeat is enabled.
                     if (repeat_en[gi]) begin
                        state_next  = ST_REPEAT;
                        rp_cnt_next = '0;
                     end
                  end else begin
                     rp_cnt_next = rp_cnt_reg + 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (!repeat_en[gi]) begin
                     state_next  = ST_HOLD;
                     rp_cnt_next = '0;
                  end else if (rp_cnt_reg == REP_LAST) begin
                     rp_cnt_next = '0;
                  end else begin
                     rp_cnt_next = rp_cnt_reg + 1'b1;
                  end
               end
               default: begin
                  state_next  = ST_IDLE;
                  rp_cnt_next = '0;
               end
            endcase
            if (fall_evt) begin
               state_next  = ST_IDLE;
               rp_cnt_next = '0;
            end
         end

         // A release suppresses any repeat falling due in the same cycle.
         always_comb begin
            repeat_next = 1'b0;
            if (!fall_evt) begin
               case (state_reg)
                  ST_HOLD:   repeat_next = repeat_en[gi] && (rp_cnt_reg == HOLD_LAST);
                  ST_REPEAT: repeat_next = repeat_en[gi] && (rp_cnt_reg == REP_LAST);
                  default:   repeat_next = 1'b0;
               endcase
            end
         end

         assign key_level[gi]   = level_reg;
         assign key_press[gi]   = press_reg;
         assign key_release[gi] = release_reg;
         assign key_repeat[gi]  = repeat_reg;
      end
   endgenerate

endmodule

// File: tb/tb_wasde_key_debounce.sv
// Scoreboard bench for wasde_key_debounce: stimulus queues expected pulse
// events by clock edge, a negedge monitor pops and compares them.
module tb_wasde_key_debounce;

   localparam int DEB = 4;
   localparam int HLD = 10;
   localparam int REP = 5;
   // raw driven after edge e: s1 at e+1, s2 at e+2, DEB count edges
   localparam int LAT = 2 + DEB;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] key_raw;
   logic [4:0] repeat_en;
   logic [4:0] key_level;
   logic [4:0] key_press;
   logic [4:0] key_release;
   logic [4:0] key_repeat;

   wasde_key_debounce #(
      .N_KEYS(5),
      .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES(HLD),
      .REPEAT_CYCLES(REP),
      .CNT_W(26)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key_raw(key_raw),
      .repeat_en(repeat_en),
      .key_level(key_level),
      .key_press(key_press),
      .key_release(key_release),
      .key_repeat(key_repeat)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef struct {
      int         cyc;
      logic [4:0] press;
      logic [4:0] rel;
      logic [4:0] rep;
      logic [4:0] lvl;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0;
   int n_err = 0;
   logic [4:0] cur_lvl = 5'h00;

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, got, exp, edge_n);
      end
   endtask

   task automatic push(input int cyc, input logic [4:0] p, input logic [4:0] r,
                       input logic [4:0] rp, input logic [4:0] l);
      exp_t e;
      e.cyc = cyc; e.press = p; e.rel = r; e.rep = rp; e.lvl = l;
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic to_edge(input int target);
      while (edge_n < target) step(1);
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         chk("reset_outputs", int'({key_level, key_press, key_release, key_repeat}), 0);
         cur_lvl = 5'h00;
      end else if ((|key_press) || (|key_release) || (|key_repeat)) begin
         if (q.size() == 0) begin
            chk("unexpected_pulse", int'({key_press, key_release, key_repeat}), 0);
         end else begin
            e = q.pop_front();
            $display("edge=%0d press=%b release=%b repeat=%b level=%b",
                     edge_n, key_press, key_release, key_repeat, key_level);
            chk("event_edge", edge_n, e.cyc);
            chk("key_press", int'(key_press), int'(e.press));
            chk("key_release", int'(key_release), int'(e.rel));
            chk("key_repeat", int'(key_repeat), int'(e.rep));
            chk("key_level", int'(key_level), int'(e.lvl));
            cur_lvl = e.lvl;
         end
      end else if (q.size() > 0 && q[0].cyc <= edge_n) begin
         e = q.pop_front();
         chk("missing_event", 0, int'({e.press, e.rel, e.rep}));
         cur_lvl = e.lvl;
      end else begin
         chk("idle_level", int'(key_level), int'(cur_lvl));
      end
   end

   initial begin
      int p;
      int p2;
      rst       = 1'b1;
      key_raw   = 5'h1F;
      repeat_en = 5'h00;

      // 1: reset with all keys held, then fresh press on all five
      step(3);
      rst = 1'b0;
      push(edge_n + LAT, 5'h1F, 5'h00, 5'h00, 5'h1F);
      step(12);
      key_raw = 5'h00;
      push(edge_n + LAT, 5'h00, 5'h1F, 5'h00, 5'h00);
      step(10);

      // 2: clean press and release on W
      key_raw = 5'b10000;
      push(edge_n + LAT, 5'b10000, 5'h00, 5'h00, 5'b10000);
      step(8);
      key_raw = 5'h00;
      push(edge_n + LAT, 5'h00, 5'b10000, 5'h00, 5'h00);
      step(10);

      // 3: bounce on E, then hold
      key_raw[0] = 1'b1; step(2);
      key_raw[0] = 1'b0; step(1);
      key_raw[0] = 1'b1; step(3);
      key_raw[0] = 1'b0; step(2);
      key_raw[0] = 1'b1;
      push(edge_n + LAT, 5'b00001, 5'h00, 5'h00, 5'b00001);
      step(8);
      key_raw = 5'h00;
      push(edge_n + LAT, 5'h00, 5'b00001, 5'h00, 5'h00);
      step(10);

      // 4: auto-repeat on S, then A held with repeat disabled
      repeat_en = 5'b00100;
      key_raw   = 5'b00100;
      p = edge_n + LAT;
      push(p, 5'b00100, 5'h00, 5'h00, 5'b00100);
      for (int i = 0; i < 7; i++) push(p + HLD + REP * i, 5'h00, 5'h00, 5'b00100, 5'b00100);
      to_edge(p + 36);
      key_raw = 5'h00;
      push(p + 42, 5'h00, 5'b00100, 5'h00, 5'h00);
      step(10);
      key_raw = 5'b01000;
      p = edge_n + LAT;
      push(p, 5'b01000, 5'h00, 5'h00, 5'b01000);
      to_edge(p + 36);
      key_raw = 5'h00;
      push(p + 42, 5'h00, 5'b01000, 5'h00, 5'h00);
      step(10);

      // 5: release lands on a due repeat; FSM must restart cleanly afterwards
      key_raw = 5'b00100;
      p = edge_n + LAT;
      push(p, 5'b00100, 5'h00, 5'h00, 5'b00100);
      push(p + HLD, 5'h00, 5'h00, 5'b00100, 5'b00100);
      push(p + HLD + REP, 5'h00, 5'h00, 5'b00100, 5'b00100);
      to_edge(p + HLD + 2 * REP - LAT);
      key_raw = 5'h00;
      push(p + HLD + 2 * REP, 5'h00, 5'b00100, 5'h00, 5'h00);
      step(15);
      key_raw = 5'b00100;
      p = edge_n + LAT;
      push(p, 5'b00100, 5'h00, 5'h00, 5'b00100);
      push(p + HLD, 5'h00, 5'h00, 5'b00100, 5'b00100);
      push(p + HLD + REP, 5'h00, 5'h00, 5'b00100, 5'b00100);
      to_edge(p + 12);
      key_raw = 5'h00;
      push(p + 18, 5'h00, 5'b00100, 5'h00, 5'h00);
      step(10);

      // 6: reset mid-HOLD on D, key still held through reset
      repeat_en = 5'b00010;
      key_raw   = 5'b00010;
      p = edge_n + LAT;
      push(p, 5'b00010, 5'h00, 5'h00, 5'b00010);
      to_edge(p + 5);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      p2 = edge_n + LAT;
      push(p2, 5'b00010, 5'h00, 5'h00, 5'b00010);
      push(p2 + HLD, 5'h00, 5'h00, 5'b00010, 5'b00010);
      push(p2 + HLD + REP, 5'h00, 5'h00, 5'b00010, 5'b00010);
      to_edge(p2 + 12);
      key_raw = 5'h00;
      push(p2 + 18, 5'h00, 5'b00010, 5'h00, 5'h00);
      step(10);

      // drain, bounded
      for (int i = 0; i < 100 && q.size() > 0; i++) step(1);
      chk("queue_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
